// File: rtl/game_sequencer.sv
// Move sequencer for the game datapath: buffers host move pairs, runs one
// setup cycle, then issues one move per round and tallies the outcomes.
module game_sequencer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       cfg,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [1:0]       wr_primo,
  input  logic [1:0]       wr_secondo,
  output logic             INIZIO_SETUP,
  output logic             INIZIO_CONTO,
  output logic [1:0]       PRIMO,
  output logic [1:0]       SECONDO,
  input  logic [1:0]       MANCHE,
  input  logic [1:0]       PARTITA,
  output logic             busy,
  output logic             done,
  output logic [1:0]       winner,
  output logic [CNT_W-1:0] rounds,
  output logic [CNT_W-1:0] invalid
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PLAY,
    RESULT,
    DONE
  } state_t;

  state_t state, state_next;

  logic [3:0]    mem [DEPTH];
  logic [3:0]    head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, wr_fire, pop, flush;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign wr_ready = !full;
  assign wr_fire  = wr_valid && !full;
  assign head     = mem[rd_ptr];
  assign pop      = (state == PLAY) && !empty;
  // Match end flushes the queue; a write landing on that same edge survives.
  assign flush    = (state == RESULT) && (PARTITA != 2'b00);

  assign busy = (state == SETUP) || (state == PLAY) || (state == RESULT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr] <= {wr_secondo, wr_primo};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (flush) begin
        rd_ptr <= wr_ptr;
        count  <= {{AW{1'b0}}, wr_fire};
      end else begin
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({wr_fire, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next   = state;
    INIZIO_SETUP = 1'b0;
    INIZIO_CONTO = 1'b0;
    PRIMO        = 2'b00;
    SECONDO      = 2'b00;
    case (state)
      IDLE: begin
        if (start) state_next = SETUP;
      end
      SETUP: begin
        INIZIO_SETUP = 1'b1;
        PRIMO        = cfg[1:0];
        SECONDO      = cfg[3:2];
        state_next   = PLAY;
      end
      PLAY: begin
        if (!empty) begin
          INIZIO_CONTO = 1'b1;
          PRIMO        = head[1:0];
          SECONDO      = head[3:2];
          state_next   = RESULT;
        end
      end
      RESULT: begin
        state_next = (PARTITA != 2'b00) ? DONE : PLAY;
      end
      DONE: begin
        if (start) state_next = SETUP;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winner  <= '0;
      rounds  <= '0;
      invalid <= '0;
    end else if (state == SETUP) begin
      winner  <= '0;
      rounds  <= '0;
      invalid <= '0;
    end else if (state == RESULT) begin
      if (MANCHE == 2'b00) begin
        if (invalid != '1) invalid <= invalid + 1'b1;
      end else begin
        if (rounds != '1) rounds <= rounds + 1'b1;
      end
      if (PARTITA != 2'b00) winner <= PARTITA;
    end
  end

endmodule
